// File: rtl/vga_pattern_pkg.sv
// vga_pattern_pkg: shared pattern modes and constants for the VGA pattern engine
package vga_pattern_pkg;
    typedef enum logic [1:0] {
        PAT_STRIPES = 2'd0,
        PAT_CHECKER = 2'd1,
        PAT_BARS    = 2'd2,
        PAT_SOLID   = 2'd3
    } pat_mode_t;
    localparam int STRIPE_MID    = 5;
    localparam int STRIPE_FINE   = 2;
    localparam int STRIPE_COARSE = 7;
    localparam int FRAME_W       = 8;
endpackage

// File: rtl/vga_scroll_ctrl.sv
// vga_scroll_ctrl: frame tick detect, scroll offsets, per-frame mode/colour latch and frame counter
module vga_scroll_ctrl
    import vga_pattern_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int COLOR_W  = 2,
    parameter int V_ACTIVE = 480
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COORD_W-1:0]   hpos,
    input  logic [COORD_W-1:0]   vpos,
    input  logic [1:0]           mode,
    input  logic [2:0]           speed,
    input  logic                 dir,
    input  logic [1:0]           axis,
    input  logic                 pause,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic [COORD_W-1:0]   x_off,
    output logic [COORD_W-1:0]   y_off,
    output pat_mode_t            mode_q,
    output logic [3*COLOR_W-1:0] solid_q,
    output logic [FRAME_W-1:0]   frame_cnt
);
    logic               tick;
    logic [COORD_W-1:0] step;

    assign tick = (hpos == '0) && (vpos == COORD_W'(V_ACTIVE));
    assign step = COORD_W'(speed);

    // once per frame: latch mode/colour always, advance offsets and counter unless paused
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_off     <= '0;
            y_off     <= '0;
            mode_q    <= PAT_STRIPES;
            solid_q   <= '0;
            frame_cnt <= '0;
        end else if (tick) begin
            mode_q  <= pat_mode_t'(mode);
            solid_q <= solid_rgb;
            if (!pause) begin
                frame_cnt <= frame_cnt + 1'b1;
                if (axis[0]) x_off <= dir ? x_off - step : x_off + step;
                if (axis[1]) y_off <= dir ? y_off - step : y_off + step;
            end
        end
    end
endmodule

// File: rtl/vga_pattern_engine.sv
// vga_pattern_engine: scrolling test-pattern generator with one-stage registered RGB/sync outputs (optional border: VGA_PAT_BORDER_EN)
module vga_pattern_engine
    import vga_pattern_pkg::*;
#(
    parameter int   COORD_W    = 10,
    parameter int   COLOR_W    = 2,
    parameter int   V_ACTIVE   = 480,
    parameter int   CHECK_LOG2 = 4,
`ifdef VGA_PAT_BORDER_EN
    parameter int   H_LAST     = 639,
`endif
    parameter logic SYNC_RESET = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COORD_W-1:0]   hpos,
    input  logic [COORD_W-1:0]   vpos,
    input  logic                 display_on,
    input  logic                 hsync_i,
    input  logic                 vsync_i,
    input  logic [1:0]           mode,
    input  logic [2:0]           speed,
    input  logic                 dir,
    input  logic [1:0]           axis,
    input  logic                 pause,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic [COLOR_W-1:0]   r_o,
    output logic [COLOR_W-1:0]   g_o,
    output logic [COLOR_W-1:0]   b_o,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 display_o,
    output logic [FRAME_W-1:0]   frame_cnt
);
    logic [COORD_W-1:0]   x_off, y_off, mx, my;
    logic [3*COLOR_W-1:0] solid_q;
    logic [COLOR_W-1:0]   r_n, g_n, b_n;
    pat_mode_t            mode_q;
    logic                 chk;
    logic                 unused_bits;

    vga_scroll_ctrl #(
        .COORD_W  (COORD_W),
        .COLOR_W  (COLOR_W),
        .V_ACTIVE (V_ACTIVE)
    ) u_scroll (
        .clk       (clk),
        .reset     (reset),
        .hpos      (hpos),
        .vpos      (vpos),
        .mode      (mode),
        .speed     (speed),
        .dir       (dir),
        .axis      (axis),
        .pause     (pause),
        .solid_rgb (solid_rgb),
        .x_off     (x_off),
        .y_off     (y_off),
        .mode_q    (mode_q),
        .solid_q   (solid_q),
        .frame_cnt (frame_cnt)
    );

    assign mx          = hpos - x_off;
    assign my          = vpos - y_off;
    assign chk         = mx[CHECK_LOG2] ^ my[CHECK_LOG2];
    assign unused_bits = ^{mx, my};

`ifdef VGA_PAT_BORDER_EN
    logic border;
    assign border = (hpos == '0) || (vpos == '0) ||
                    (vpos == COORD_W'(V_ACTIVE - 1)) || (hpos == COORD_W'(H_LAST));
`endif

    // pattern select; bit 0 of each stripe channel carries the vertical term
    always_comb begin
        r_n = '0;
        g_n = '0;
        b_n = '0;
        case (mode_q)
            PAT_STRIPES: for (int i = 0; i < COLOR_W; i++) begin
                r_n[i] = (i == 0) ? my[STRIPE_FINE] : mx[STRIPE_MID];
                g_n[i] = (i == 0) ? my[STRIPE_FINE] : mx[STRIPE_FINE];
                b_n[i] = (i == 0) ? my[STRIPE_MID]  : mx[STRIPE_COARSE];
            end
            PAT_CHECKER: {r_n, g_n, b_n} = {(3*COLOR_W){chk}};
            PAT_BARS: begin
                r_n = {COLOR_W{mx[COORD_W-1]}};
                g_n = {COLOR_W{mx[COORD_W-2]}};
                b_n = {COLOR_W{mx[COORD_W-3]}};
            end
            default: {r_n, g_n, b_n} = solid_q;
        endcase
`ifdef VGA_PAT_BORDER_EN
        if (border) {r_n, g_n, b_n} = '1;
`endif
    end

    // single output stage: blanked colour plus syncs and display flag share the same delay
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_o       <= '0;
            g_o       <= '0;
            b_o       <= '0;
            hsync_o   <= SYNC_RESET;
            vsync_o   <= SYNC_RESET;
            display_o <= 1'b0;
        end else begin
            r_o       <= display_on ? r_n : '0;
            g_o       <= display_on ? g_n : '0;
            b_o       <= display_on ? b_n : '0;
            hsync_o   <= hsync_i;
            vsync_o   <= vsync_i;
            display_o <= display_on;
        end
    end
endmodule

// File: tb/tb_vga_pattern_engine.sv
// tb_vga_pattern_engine: directed + randomized checks of vga_pattern_engine against a frame-level reference model
module tb_vga_pattern_engine;
    logic       clk = 0, reset = 0;
    logic [9:0] hpos = 0, vpos = 0;
    logic       display_on = 0, hsync_i = 0, vsync_i = 0;
    logic [1:0] mode = 0, axis = 0;
    logic [2:0] speed = 0;
    logic       dir = 0, pause = 0;
    logic [5:0] solid_rgb = 0;
    logic [1:0] r_o, g_o, b_o;
    logic       hsync_o, vsync_o, display_o;
    logic [7:0] frame_cnt;

    int total = 0, bad = 0;
    int xo, yo, m_mode, m_solid, fc;
    int pr_hs, pr_vs;

    vga_pattern_engine dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .mode(mode), .speed(speed), .dir(dir),
        .axis(axis), .pause(pause), .solid_rgb(solid_rgb), .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .display_o(display_o), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int bit_of(input int v, input int b);
        return (v >> b) & 1;
    endfunction

    // expected pixel from the frame-level model state (2 bits per channel)
    task automatic exp_pix(input int h, input int v, input bit d, output int er, output int eg, output int eb);
        int mx, my, c, bb;
        mx = (h - xo) & 1023;
        my = (v - yo) & 1023;
        case (m_mode)
            0: begin
                er = bit_of(mx, 5) * 2 + bit_of(my, 2);
                eg = bit_of(mx, 2) * 2 + bit_of(my, 2);
                eb = bit_of(mx, 7) * 2 + bit_of(my, 5);
            end
            1: begin
                c = bit_of(mx, 4) ^ bit_of(my, 4);
                er = c * 3; eg = c * 3; eb = c * 3;
            end
            2: begin
                bb = mx / 128;
                er = bit_of(bb, 2) * 3; eg = bit_of(bb, 1) * 3; eb = bit_of(bb, 0) * 3;
            end
            default: begin
                er = m_solid / 16; eg = (m_solid / 4) % 4; eb = m_solid % 4;
            end
        endcase
`ifdef VGA_PAT_BORDER_EN
        if (h == 0 || v == 0 || v == 479 || h == 639) begin er = 3; eg = 3; eb = 3; end
`endif
        if (!d) begin er = 0; eg = 0; eb = 0; end
    endtask

    task automatic model_reset();
        xo = 0; yo = 0; m_mode = 0; m_solid = 0; fc = 0;
    endtask

    // one clock: drive beam inputs, predict, advance model, compare every output
    task automatic step(input int h, input int v, input bit d, input bit hs, input bit vs);
        int er, eg, eb;
        hpos = 10'(h); vpos = 10'(v); display_on = d; hsync_i = hs; vsync_i = vs;
        exp_pix(h, v, d, er, eg, eb);
        @(posedge clk); #1;
        if (h == 0 && v == 480) begin
            m_mode = int'(mode); m_solid = int'(solid_rgb);
            if (!pause) begin
                fc = (fc + 1) % 256;
                if (axis[0]) xo = dir ? (xo - int'(speed)) & 1023 : (xo + int'(speed)) & 1023;
                if (axis[1]) yo = dir ? (yo - int'(speed)) & 1023 : (yo + int'(speed)) & 1023;
            end
        end
        chk("r", 32'(r_o), er);
        chk("g", 32'(g_o), eg);
        chk("b", 32'(b_o), eb);
        chk("hsync", 32'(hsync_o), hs);
        chk("vsync", 32'(vsync_o), vs);
        chk("display", 32'(display_o), d);
        chk("frame_cnt", 32'(frame_cnt), fc);
    endtask

    task automatic tick();
        step(0, 480, 0, 0, 0);
    endtask

    // asynchronous reset asserted between edges; outputs must clear without a clock
    task automatic do_reset();
        #2 reset = 1;
        #1;
        chk("rst_r", 32'(r_o), 0);
        chk("rst_g", 32'(g_o), 0);
        chk("rst_b", 32'(b_o), 0);
        chk("rst_hsync", 32'(hsync_o), 0);
        chk("rst_vsync", 32'(vsync_o), 0);
        chk("rst_display", 32'(display_o), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        model_reset();
        @(negedge clk) reset = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #3;
        do_reset();

        // stripes scrolling right by 1 per frame
        mode = 0; speed = 1; dir = 0; axis = 2'b01;
        repeat (3) tick();
        step(35, 4, 1, 1, 0);
        chk("stripe_px35_r", 32'(r_o), 3);

        // y scroll backwards wraps below zero
        do_reset();
        dir = 1; speed = 5; axis = 2'b10;
        tick();
        chk("yoff_wrap_fc", 32'(frame_cnt), 1);
        step(10, 1019 - 1019 + 3, 1, 0, 1);

        // pause with a mid-frame mode change: nothing advances, mode applies at next tick
        pause = 1; mode = 2;
        step(128, 8, 1, 0, 0);
        repeat (4) tick();
        chk("pause_fc", 32'(frame_cnt), 1);
        step(128, 8, 1, 1, 1);
        chk("bars_r", 32'(r_o), 0);
        chk("bars_g", 32'(g_o), 0);
        chk("bars_b", 32'(b_o), 3);

        // solid colour with display toggling
        pause = 0; mode = 3; solid_rgb = 6'b11_00_01;
        tick();
        for (int i = 0; i < 6; i++) step(200 + i, 50, i[0], i[1], ~i[0]);
        step(300, 60, 1, 1, 1);
        chk("solid_r", 32'(r_o), 3);
        chk("solid_b", 32'(b_o), 1);

        // reset mid-line with active outputs
        do_reset();

        // randomized controls and beam positions
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                mode = 2'($urandom); speed = 3'($urandom); dir = 1'($urandom);
                axis = 2'($urandom); pause = ($urandom_range(0, 3) == 0);
                solid_rgb = 6'($urandom);
            end
            if ($urandom_range(0, 7) == 0) step(0, 480, 1'($urandom), 1'($urandom), 1'($urandom));
            else if ($urandom_range(0, 15) == 0)
                step(($urandom_range(0, 1) == 1) ? 639 : 0, $urandom_range(0, 479), 1, 1'($urandom), 1'($urandom));
            else
                step($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // frame counter wrap
        do_reset();
        pause = 0; axis = 0;
        repeat (255) tick();
        chk("fc_255", 32'(frame_cnt), 255);
        tick();
        chk("fc_wrap", 32'(frame_cnt), 0);

`ifdef VGA_PAT_BORDER_EN
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            tick();
            step(0, 100, 1, 0, 0);
            chk("border_r", 32'(r_o), 3);
            chk("border_g", 32'(g_o), 3);
            chk("border_b", 32'(b_o), 3);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
